// File: rtl/sqrt_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// sqrt_share_arbiter_if
//   Bundles the requester-side and sqrt-unit-side signals of the shared
//   square-root arbiter.
//
//   Requester side : req_valid, req_data  -> arbiter
//                    req_ready, resp_valid, resp_data, resp_err <- arbiter
//   Sqrt-unit side : sqrt_start, sqrt_in  <- arbiter
//                    sqrt_done, sqrt_out  -> arbiter
//   Status         : busy                 <- arbiter
//
//   modport slave  : the arbiter's view
//   modport master : the environment's view (requesters plus the sqrt unit)
// ---------------------------------------------------------------------------
interface sqrt_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 48,
  parameter int OUT_W   = 32
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*IN_W-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      resp_valid;
  logic [OUT_W-1:0]        resp_data;
  logic                    resp_err;
  logic                    sqrt_start;
  logic [IN_W-1:0]         sqrt_in;
  logic                    sqrt_done;
  logic [OUT_W-1:0]        sqrt_out;
  logic                    busy;

  modport slave (
    input  req_valid, req_data, sqrt_done, sqrt_out,
    output req_ready, resp_valid, resp_data, resp_err,
           sqrt_start, sqrt_in, busy
  );

  modport master (
    output req_valid, req_data, sqrt_done, sqrt_out,
    input  req_ready, resp_valid, resp_data, resp_err,
           sqrt_start, sqrt_in, busy
  );
endinterface

// File: rtl/sqrt_share_arbiter.sv
// ---------------------------------------------------------------------------
// sqrt_share_arbiter
//   Shares one non-pipelined iterative square-root unit among NUM_REQ
//   requesters (brightness- and chromaticity-distortion stages).
//   Requesters are served round-robin, one operation at a time. Each
//   operation issues a single start pulse, waits for the unit's done pulse
//   under a watchdog, and returns the root to the owning requester only.
//   A zero radicand is answered directly without starting the unit.
//
// Ports
//   clk            clock
//   rst            synchronous, active-high reset
//   bus.req_valid  per-requester request strobe, held until accepted
//   bus.req_data   radicands, requester i at [i*IN_W +: IN_W]
//   bus.req_ready  one-hot accept pulse (combinational, IDLE only)
//   bus.resp_valid one-hot one-cycle result pulse to the owner (registered)
//   bus.resp_data  root, meaningful only with resp_valid (registered)
//   bus.resp_err   watchdog expired for this response (registered)
//   bus.sqrt_start one-cycle start pulse to the unit (registered)
//   bus.sqrt_in    radicand to the unit, stable from ISSUE through WAIT
//   bus.sqrt_done  unit completion pulse
//   bus.sqrt_out   unit result, valid with sqrt_done
//   bus.busy       high whenever the FSM is not IDLE (combinational)
// ---------------------------------------------------------------------------
module sqrt_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 48,
  parameter int OUT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  sqrt_share_arbiter_if.slave  bus
);

  localparam int          GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          CW = 16;
  localparam int unsigned NR = NUM_REQ;

  localparam logic [GW-1:0]      LAST_IDX  = GW'(NUM_REQ - 1);
  localparam logic [CW-1:0]      CNT_LIMIT = CW'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]         state;
  logic [GW-1:0]      last_grant;
  logic [GW-1:0]      owner;
  logic [CW-1:0]      wd_cnt;

  logic [GW-1:0]      grant;
  logic               grant_vld;
  logic [IN_W-1:0]    grant_data;
  int unsigned        scan_idx;

  logic [NUM_REQ-1:0] resp_valid_q;
  logic [OUT_W-1:0]   resp_data_q;
  logic               resp_err_q;
  logic               sqrt_start_q;
  logic [IN_W-1:0]    sqrt_in_q;

  // Round-robin pick: scan upward from last_grant+1, wrapping, and take the
  // first requester that is currently valid. Offsets run 1..NUM_REQ so the
  // previous owner is considered last.
  always_comb begin
    grant     = last_grant;
    grant_vld = 1'b0;
    scan_idx  = 0;
    for (int unsigned k = 1; k <= NR; k++) begin
      scan_idx = 32'(last_grant) + k;
      if (scan_idx >= NR) begin
        scan_idx = scan_idx - NR;
      end
      if (!grant_vld && bus.req_valid[GW'(scan_idx)]) begin
        grant     = GW'(scan_idx);
        grant_vld = 1'b1;
      end
    end
  end

  // Radicand of the selected requester.
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (grant == GW'(i)) begin
        grant_data = bus.req_data[i*IN_W +: IN_W];
      end
    end
  end

  assign bus.req_ready  = (state == S_IDLE && grant_vld) ? (ONE_HOT0 << grant) : '0;
  assign bus.busy       = (state != S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.sqrt_start = sqrt_start_q;
  assign bus.sqrt_in    = sqrt_in_q;

  // The registered outputs are loaded on the transition into the state in
  // which they must be visible: sqrt_start on IDLE->ISSUE, the response
  // fields on IDLE->RESP (zero bypass) or WAIT->RESP. Pulses default low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      last_grant   <= LAST_IDX;
      owner        <= '0;
      wd_cnt       <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      sqrt_start_q <= 1'b0;
      sqrt_in_q    <= '0;
    end else begin
      sqrt_start_q <= 1'b0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            owner <= grant;
            if (grant_data == '0) begin
              // sqrt(0) = 0: answer directly, the unit is never started.
              resp_valid_q <= ONE_HOT0 << grant;
              resp_data_q  <= '0;
              state        <= S_RESP;
            end else begin
              sqrt_in_q    <= grant_data;
              sqrt_start_q <= 1'b1;
              state        <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end

        S_WAIT: begin
          // A done that lands on the limit cycle still counts as success.
          if (bus.sqrt_done) begin
            resp_valid_q <= ONE_HOT0 << owner;
            resp_data_q  <= bus.sqrt_out;
            state        <= S_RESP;
          end else if (wd_cnt == CNT_LIMIT) begin
            resp_valid_q <= ONE_HOT0 << owner;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            state        <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end

        S_RESP: begin
          last_grant <= owner;
          state      <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sqrt_share_arbiter
//   Directed bench for sqrt_share_arbiter (NUM_REQ=4, IN_W=48, OUT_W=32,
//   TIMEOUT=8). A table of transactions drives the main flow; the sqrt unit
//   is emulated by pulsing sqrt_done after a per-entry latency. Hand-written
//   sequences cover stale done pulses and reset in the middle of WAIT.
// ---------------------------------------------------------------------------
module tb_sqrt_share_arbiter;
  localparam int N  = 4;
  localparam int IW = 48;
  localparam int OW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sqrt_share_arbiter_if #(.NUM_REQ(N), .IN_W(IW), .OUT_W(OW)) bus ();

  sqrt_share_arbiter #(
    .NUM_REQ(N),
    .IN_W   (IW),
    .OUT_W  (OW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit              pre_rst;   // reset the DUT before this entry
    logic [N-1:0]    valid;     // req_valid pattern applied
    logic [N*IW-1:0] data;      // req_data applied
    int              g;         // expected grant
    int              lat;       // done latency after start (0 = never)
    logic [OW-1:0]   uval;      // value the unit returns
    logic [OW-1:0]   exp_data;  // expected resp_data
    logic            exp_err;   // expected resp_err
    bit              hold;      // keep req_valid[g] high after accept
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance to the drive point of the next cycle (2 time units after posedge).
  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] one;
    one = 1;
    return one << g;
  endfunction

  task automatic do_reset(input int n);
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.sqrt_done  = 1'b0;
    repeat (n) adv();
    rst = 1'b0;
  endtask

  // One complete transaction; called at the drive point of a cycle.
  task automatic run_txn(input vec_t v, input string name);
    int          t;
    int          eff;
    int          rc;
    logic [IW-1:0] din;
    din = v.data[v.g*IW +: IW];
    bus.req_valid = v.valid;
    bus.req_data  = v.data;
    #1;
    t = 0;
    while (bus.req_ready == '0 && t < 20) begin
      adv();
      #1;
      t++;
    end
    check({name, "_ready"}, bus.req_ready, oh(v.g));
    check({name, "_busy_accept"}, bus.busy, 1'b0);
    eff = (v.lat == 0 || v.lat > TO) ? TO : v.lat;
    rc  = (din == '0) ? 1 : 2 + eff;
    for (int c = 1; c < rc; c++) begin
      adv();
      if (c == 1 && !v.hold) bus.req_valid[v.g] = 1'b0;
      bus.sqrt_done = (v.lat > 0 && c == 1 + v.lat);
      bus.sqrt_out  = bus.sqrt_done ? v.uval : 32'hDEAD_BEEF;
      #1;
      check({name, "_start"}, bus.sqrt_start, (c == 1));
      check({name, "_sqrt_in"}, bus.sqrt_in, din);
      check({name, "_quiet"}, {bus.resp_valid, bus.req_ready}, '0);
      check({name, "_busy"}, bus.busy, 1'b1);
    end
    adv();
    bus.sqrt_done = 1'b0;
    #1;
    check({name, "_resp_valid"}, bus.resp_valid, oh(v.g));
    check({name, "_resp_data"}, bus.resp_data, v.exp_data);
    check({name, "_resp_err"}, bus.resp_err, v.exp_err);
    check({name, "_resp_nostart"}, bus.sqrt_start, 1'b0);
    adv();
    #1;
    check({name, "_resp_end"}, bus.resp_valid, '0);
    check({name, "_idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    // {d3, d2, d1, d0}
    vecs[0]  = '{1'b1, 4'b0010, {48'd0, 48'd0, 48'd144, 48'd0}, 1, 5, 32'd12, 32'd12, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'b1111, {48'd16, 48'd9, 48'd4, 48'd1}, 0, 2, 32'd1, 32'd1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 4'b1111, {48'd16, 48'd9, 48'd4, 48'd1}, 1, 3, 32'd2, 32'd2, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 4'b1111, {48'd16, 48'd9, 48'd4, 48'd1}, 2, 1, 32'd3, 32'd3, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 4'b1111, {48'd16, 48'd9, 48'd4, 48'd1}, 3, 4, 32'd4, 32'd4, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 4'b1111, {48'd16, 48'd9, 48'd4, 48'd1}, 0, 2, 32'd1, 32'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'b0100, {48'd0, 48'd0, 48'd0, 48'd0}, 2, 1, 32'd5, 32'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'b1000, {48'd49, 48'd0, 48'd0, 48'd0}, 3, 8, 32'd7, 32'd7, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b0001, {48'd0, 48'd0, 48'd0, 48'd25}, 0, 0, 32'd5, 32'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'b1001, {48'd9, 48'd0, 48'd0, 48'd4}, 0, 1, 32'd2, 32'd2, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'b1000, {48'd9, 48'd0, 48'd0, 48'd4}, 3, 2, 32'd3, 32'd3, 1'b0, 1'b0};

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.sqrt_done = 1'b0;
    bus.sqrt_out  = '0;
    rst = 1'b1;
    adv();
    adv();
    #1;
    check("rst_req_ready", bus.req_ready, '0);
    check("rst_resp_valid", bus.resp_valid, '0);
    check("rst_resp_data", bus.resp_data, '0);
    check("rst_resp_err", bus.resp_err, 1'b0);
    check("rst_sqrt_start", bus.sqrt_start, 1'b0);
    check("rst_sqrt_in", bus.sqrt_in, '0);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;

    // Table-driven main flow: single, round-robin, zero bypass, tie, watchdog.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].pre_rst) do_reset(2);
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Stale done in IDLE after the watchdog fired: no response.
    bus.req_valid = '0;
    adv();
    bus.sqrt_done = 1'b1;
    bus.sqrt_out  = 32'd99;
    #1;
    check("late_done_busy", bus.busy, 1'b0);
    adv();
    bus.sqrt_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("late_done_resp", {bus.resp_valid, bus.sqrt_start, bus.busy}, '0);
      adv();
    end

    // Reset during WAIT, with done coincident with and following reset.
    bus.req_valid = 4'b0001;
    bus.req_data  = {48'd0, 48'd0, 48'd0, 48'd81};
    #1;
    check("midrst_ready", bus.req_ready, oh(0));
    adv();
    bus.req_valid = '0;
    adv();
    adv();
    #1;
    check("midrst_in_wait", bus.busy, 1'b1);
    rst           = 1'b1;
    bus.sqrt_done = 1'b1;
    bus.sqrt_out  = 32'd9;
    adv();
    rst = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_sqrt_in", bus.sqrt_in, '0);
    check("midrst_resp0", bus.resp_valid, '0);
    adv();
    bus.sqrt_done = 1'b0;
    #1;
    check("midrst_resp1", bus.resp_valid, '0);
    adv();
    #1;
    check("midrst_resp2", {bus.resp_valid, bus.busy}, '0);

    // After reset requester 0 has first priority over requester 3.
    run_txn(vecs[9], "post_rst_r0");
    run_txn(vecs[10], "post_rst_r3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
